// File: rtl/display_pkg.sv
// display_pkg: shared state encoding and BCD constants for the display converters
package display_pkg;
  localparam int BCD_NIBBLE = 4;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic longint unsigned max_bcd(input int digits);
    longint unsigned m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction
endpackage

// File: rtl/bcd_add3_cell.sv
// bcd_add3_cell: per-digit double-dabble correction, add 3 when the digit is 5 or more
module bcd_add3_cell (
  input  logic [3:0] a,
  output logic [3:0] y
);
  // a digit is at most 9 here, so the 4-bit sum never wraps
  always_comb y = (a >= 4'd5) ? a + 4'd3 : a;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 binary to packed BCD converter with held result
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             bin_in,
  output logic                         ready,
  output logic                         done,
  output logic [BCD_NIBBLE*DIGITS-1:0] bcd_out,
  output logic                         overflow
);
  localparam int bcd_w = BCD_NIBBLE * DIGITS;
  localparam int cmp_w = (WIDTH > bcd_w) ? WIDTH : bcd_w;
  localparam int cnt_w = $clog2(WIDTH + 1);
  localparam logic [cmp_w-1:0] max_val = cmp_w'(max_bcd(DIGITS));
  localparam logic [cnt_w-1:0] last = cnt_w'(WIDTH - 1);
  state_t             state;
  logic [WIDTH-1:0]   bin;
  logic [bcd_w-1:0]   scratch;
  logic [bcd_w-1:0]   corr;
  logic [bcd_w-1:0]   scratch_n;
  logic [cnt_w-1:0]   cnt;
  logic               ovf_flag;
  for (genvar i = 0; i < DIGITS; i++) begin : g_cell
    bcd_add3_cell u_cell (
      .a(scratch[i*BCD_NIBBLE +: BCD_NIBBLE]),
      .y(corr[i*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end
  // corrected scratch shifted left with the next binary bit; carry out of the top digit is dropped
  always_comb scratch_n = bcd_w'({corr, bin[WIDTH-1]});
  // conversion FSM: capture on start, WIDTH shift steps, publish result with a one-cycle done
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      bin      <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          bin      <= bin_in;
          scratch  <= '0;
          cnt      <= '0;
          ovf_flag <= cmp_w'(bin_in) > max_val;
          ready    <= 1'b0;
          state    <= SHIFT;
        end
      end else begin
        bin     <= bin << 1;
        scratch <= scratch_n;
        cnt     <= cnt + 1'b1;
        if (cnt == last) begin
          bcd_out  <= ovf_flag ? {DIGITS{4'h9}} : scratch_n;
          overflow <= ovf_flag;
          done     <= 1'b1;
          ready    <= 1'b1;
          state    <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scenario tasks plus a random sweep against a decimal reference model
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] bin_in;
  logic        ready;
  logic        done;
  logic [23:0] bcd_out;
  logic        overflow;
  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.WIDTH(20), .DIGITS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .ready(ready), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r = '0;
    int unsigned p = 1;
    if (v > 999999) return 24'h999999;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic kick(input logic [19:0] v);
    start  = 1'b1;
    bin_in = v;
  endtask

  task automatic measure(input int poke_at, input logic [19:0] poke_val,
                         output int lat, output int rlow, output int chg);
    logic [23:0] bcd0;
    bcd0 = bcd_out;
    @(posedge clk);
    lat = 0; rlow = 0; chg = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      start  = (lat == poke_at);
      bin_in = (lat == poke_at) ? poke_val : 20'($urandom);
      if (!ready) rlow++;
      if (done) break;
      if (bcd_out !== bcd0) chg++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready, done, overflow, bcd_out} !== {3'b100, 24'h0}) begin
      errors++;
      $display("FAIL reset: ready=%b done=%b ovf=%b bcd=%h, want 1 0 0 000000", ready, done, overflow, bcd_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat, rlow, chg;
    kick(20'd0);
    measure(0, 0, lat, rlow, chg);
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL zero_latency: got %0d want 21", lat); end
    checks++;
    if (rlow !== 20) begin errors++; $display("FAIL zero_ready_low: got %0d want 20", rlow); end
    checks++;
    if ({overflow, bcd_out} !== {1'b0, 24'h000000}) begin
      errors++; $display("FAIL zero_result: got %b %h want 0 000000", overflow, bcd_out);
    end
  endtask

  task automatic test_value();
    int lat, rlow, chg;
    kick(20'd123456);
    measure(0, 0, lat, rlow, chg);
    checks++;
    if (chg !== 0) begin errors++; $display("FAIL hold_before_done: %0d early changes want 0", chg); end
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL value_latency: got %0d want 21", lat); end
    checks++;
    if ({overflow, bcd_out} !== {1'b0, 24'h123456}) begin
      errors++; $display("FAIL value_123456: got %b %h want 0 123456", overflow, bcd_out);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rlow, chg;
    kick(20'd999999);
    measure(0, 0, lat, rlow, chg);
    checks++;
    if ({overflow, bcd_out} !== {1'b0, 24'h999999}) begin
      errors++; $display("FAIL max_value: got %b %h want 0 999999", overflow, bcd_out);
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_in_done: got %b want 1", ready); end
    kick(20'd1000000);
    measure(0, 0, lat, rlow, chg);
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL b2b_latency: got %0d want 21", lat); end
    checks++;
    if ({overflow, bcd_out} !== {1'b1, 24'h999999}) begin
      errors++; $display("FAIL b2b_overflow: got %b %h want 1 999999", overflow, bcd_out);
    end
    kick(20'hFFFFF);
    measure(0, 0, lat, rlow, chg);
    checks++;
    if ({overflow, bcd_out} !== {1'b1, 24'h999999}) begin
      errors++; $display("FAIL all_ones: got %b %h want 1 999999", overflow, bcd_out);
    end
  endtask

  task automatic test_ignored_start();
    int lat, rlow, chg, extra;
    kick(20'd42);
    measure(5, 20'd77, lat, rlow, chg);
    checks++;
    if ({lat, overflow, bcd_out} !== {32'd21, 1'b0, 24'h000042}) begin
      errors++; $display("FAIL ignored_start: lat=%0d got %b %h want 21 0 000042", lat, overflow, bcd_out);
    end
    extra = 0;
    repeat (25) begin @(negedge clk); if (done) extra++; end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL not_queued: %0d extra done pulses want 0", extra); end
  endtask

  task automatic test_abort();
    int lat, rlow, chg, extra;
    kick(20'd500000);
    @(posedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ready, done, overflow, bcd_out} !== {3'b100, 24'h0}) begin
      errors++; $display("FAIL abort_state: ready=%b done=%b ovf=%b bcd=%h want 1 0 0 000000", ready, done, overflow, bcd_out);
    end
    extra = 0;
    repeat (25) begin @(negedge clk); if (done) extra++; end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL abort_done: %0d done pulses want 0", extra); end
    kick(20'd7);
    measure(0, 0, lat, rlow, chg);
    checks++;
    if ({lat, overflow, bcd_out} !== {32'd21, 1'b0, 24'h000007}) begin
      errors++; $display("FAIL after_abort: lat=%0d got %b %h want 21 0 000007", lat, overflow, bcd_out);
    end
  endtask

  task automatic test_random();
    int lat, rlow, chg;
    int unsigned v;
    for (int n = 0; n < 1000; n++) begin
      v = $urandom_range(20'hFFFFF, 0);
      kick(20'(v));
      measure(0, 0, lat, rlow, chg);
      checks++;
      if ({lat, overflow, bcd_out} !== {32'd21, v > 999999, ref_bcd(v)}) begin
        errors++;
        $display("FAIL random %0d: lat=%0d got %b %h want 21 %b %h", v, lat, overflow, bcd_out, v > 999999, ref_bcd(v));
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_width for %0d: done=%b want 0", v, done); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_value();
    test_back_to_back();
    test_ignored_start();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
